// File: rtl/rggen_bit_field_wtrg_ex_pkg.sv
// Shared definitions for write-trigger bit fields: per-bit trigger states and
// the pulse counter width helper.
package rggen_bit_field_wtrg_ex_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_ACK = 2'd2
    } trigger_state_e;

    // Counter holds PULSE_WIDTH-1, so it needs at least one bit even for a 1-cycle pulse.
    function automatic int unsigned trigger_counter_width(input int unsigned pulse_width);
        return (pulse_width <= 2) ? 1 : $clog2(pulse_width);
    endfunction

endpackage

// File: rtl/rggen_bit_field_wtrg_ex_channel.sv
// One trigger bit: IDLE/PULSE/WAIT_ACK state machine, pulse down-counter and
// sticky overrun flag.
module rggen_trigger_channel
    import rggen_bit_field_wtrg_ex_pkg::*;
#(
    parameter int unsigned PULSE_WIDTH = 1,
    parameter bit          ACK_MODE    = 1'b0
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_fire,
    input  logic i_clear,
    input  logic i_ack,
    output logic o_trigger,
    output logic o_overrun
);

    localparam int unsigned      CW   = trigger_counter_width(PULSE_WIDTH);
    localparam logic [CW-1:0]    LOAD = CW'(PULSE_WIDTH - 1);

    trigger_state_e state_q;
    trigger_state_e state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic           overrun_q;
    logic           overrun_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_fire) begin
                    if (ACK_MODE) begin
                        state_d = WAIT_ACK;
                    end else begin
                        state_d = PULSE;
                    end
                    cnt_d = LOAD;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_ACK: begin
                if (i_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fire seen while busy (including the final busy cycle) is dropped but
        // recorded; a same-edge clear loses to the new set.
        overrun_d = (i_fire && (state_q != IDLE)) || (overrun_q && !i_clear);
    end

    assign o_trigger = (state_q != IDLE);
    assign o_overrun = overrun_q;

endmodule

// File: rtl/rggen_bit_field_wtrg_ex.sv
// Write-trigger bit field: decodes software writes into per-bit fire requests,
// instantiates one trigger channel per bit and muxes the read-back data.
module rggen_bit_field_wtrg_ex
    import rggen_bit_field_wtrg_ex_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter bit          TRIGGER_VALUE = 1'b1,
    parameter int unsigned PULSE_WIDTH   = 1,
    parameter bit          ACK_MODE      = 1'b0,
    parameter bit          READ_STATUS   = 1'b0
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sw_read_valid,
    input  logic             i_sw_write_valid,
    input  logic             i_sw_write_enable,
    input  logic [WIDTH-1:0] i_sw_mask,
    input  logic [WIDTH-1:0] i_sw_write_data,
    output logic [WIDTH-1:0] o_sw_read_data,
    output logic [WIDTH-1:0] o_sw_value,
    input  logic [WIDTH-1:0] i_value,
    input  logic [WIDTH-1:0] i_ack,
    output logic [WIDTH-1:0] o_trigger,
    output logic [WIDTH-1:0] o_busy,
    output logic [WIDTH-1:0] o_overrun
);

    logic [WIDTH-1:0] fire;
    logic [WIDTH-1:0] clear;
    logic [WIDTH-1:0] trigger;

    assign fire  = {WIDTH{i_sw_write_valid & i_sw_write_enable}} & i_sw_mask
                 & ~(i_sw_write_data ^ {WIDTH{TRIGGER_VALUE}});
    assign clear = {WIDTH{i_sw_read_valid}} & i_sw_mask;

    for (genvar g = 0; g < WIDTH; g++) begin : g_channel
        rggen_trigger_channel #(
            .PULSE_WIDTH (PULSE_WIDTH),
            .ACK_MODE    (ACK_MODE)
        ) u_channel (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_fire    (fire[g]),
            .i_clear   (clear[g]),
            .i_ack     (i_ack[g]),
            .o_trigger (trigger[g]),
            .o_overrun (o_overrun[g])
        );
    end

    assign o_trigger      = trigger;
    assign o_busy         = trigger;
    assign o_sw_value     = trigger;
    assign o_sw_read_data = READ_STATUS ? trigger : i_value;

endmodule

// File: tb/tb_rggen_bit_field_wtrg_ex.sv
// Bench for rggen_bit_field_wtrg_ex: four parameterisations share one stimulus
// stream and are checked every cycle against a per-bit remaining-cycles model.
module tb_rggen_bit_field_wtrg_ex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rv, wv, we;
    logic [7:0] mask, wd, value, ack;

    logic [7:0] o_rd[4];
    logic [7:0] o_val[4];
    logic [7:0] o_trg[4];
    logic [7:0] o_bsy[4];
    logic [7:0] o_ovr[4];

    int n_tests = 0;
    int n_fail  = 0;

    // Per-instance configuration: u0 1-cycle pulse, u1 4-cycle pulse,
    // u2 ack mode with busy read-back, u3 write-0 trigger, 8-cycle pulse, busy read-back.
    int pw_c[4]  = '{1, 4, 1, 8};
    bit tv_c[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit ack_c[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit rs_c[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};

    bit act_m[4][8];
    int rem_m[4][8];
    bit ovr_m[4][8];

    rggen_bit_field_wtrg_ex #(.WIDTH(8), .TRIGGER_VALUE(1'b1), .PULSE_WIDTH(1),
                              .ACK_MODE(1'b0), .READ_STATUS(1'b0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_sw_read_valid(rv), .i_sw_write_valid(wv),
        .i_sw_write_enable(we), .i_sw_mask(mask), .i_sw_write_data(wd),
        .o_sw_read_data(o_rd[0]), .o_sw_value(o_val[0]), .i_value(value), .i_ack(ack),
        .o_trigger(o_trg[0]), .o_busy(o_bsy[0]), .o_overrun(o_ovr[0]));

    rggen_bit_field_wtrg_ex #(.WIDTH(8), .TRIGGER_VALUE(1'b1), .PULSE_WIDTH(4),
                              .ACK_MODE(1'b0), .READ_STATUS(1'b0)) u1 (
        .i_clk(clk), .i_rst(rst), .i_sw_read_valid(rv), .i_sw_write_valid(wv),
        .i_sw_write_enable(we), .i_sw_mask(mask), .i_sw_write_data(wd),
        .o_sw_read_data(o_rd[1]), .o_sw_value(o_val[1]), .i_value(value), .i_ack(ack),
        .o_trigger(o_trg[1]), .o_busy(o_bsy[1]), .o_overrun(o_ovr[1]));

    rggen_bit_field_wtrg_ex #(.WIDTH(8), .TRIGGER_VALUE(1'b1), .PULSE_WIDTH(1),
                              .ACK_MODE(1'b1), .READ_STATUS(1'b1)) u2 (
        .i_clk(clk), .i_rst(rst), .i_sw_read_valid(rv), .i_sw_write_valid(wv),
        .i_sw_write_enable(we), .i_sw_mask(mask), .i_sw_write_data(wd),
        .o_sw_read_data(o_rd[2]), .o_sw_value(o_val[2]), .i_value(value), .i_ack(ack),
        .o_trigger(o_trg[2]), .o_busy(o_bsy[2]), .o_overrun(o_ovr[2]));

    rggen_bit_field_wtrg_ex #(.WIDTH(8), .TRIGGER_VALUE(1'b0), .PULSE_WIDTH(8),
                              .ACK_MODE(1'b0), .READ_STATUS(1'b1)) u3 (
        .i_clk(clk), .i_rst(rst), .i_sw_read_valid(rv), .i_sw_write_valid(wv),
        .i_sw_write_enable(we), .i_sw_mask(mask), .i_sw_write_data(wd),
        .o_sw_read_data(o_rd[3]), .o_sw_value(o_val[3]), .i_value(value), .i_ack(ack),
        .o_trigger(o_trg[3]), .o_busy(o_bsy[3]), .o_overrun(o_ovr[3]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_trig(input int k);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = act_m[k][b];
        return v;
    endfunction

    function automatic logic [7:0] m_ovr(input int k);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = ovr_m[k][b];
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 8; b++) begin
                act_m[k][b] = 1'b0;
                rem_m[k][b] = 0;
                ovr_m[k][b] = 1'b0;
            end
    endtask

    // Applies one clock edge to the model using the inputs the DUT just sampled.
    task automatic model_update();
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 8; b++) begin
                bit fire, set;
                fire = wv && we && mask[b] && (wd[b] == tv_c[k]);
                set  = 1'b0;
                if (act_m[k][b]) begin
                    set = fire;
                    if (ack_c[k]) begin
                        if (ack[b]) act_m[k][b] = 1'b0;
                    end else begin
                        rem_m[k][b] = rem_m[k][b] - 1;
                        if (rem_m[k][b] == 0) act_m[k][b] = 1'b0;
                    end
                end else if (fire) begin
                    act_m[k][b] = 1'b1;
                    rem_m[k][b] = pw_c[k];
                end
                ovr_m[k][b] = set | (ovr_m[k][b] & !(rv && mask[b]));
            end
    endtask

    task automatic check_rd();
        for (int k = 0; k < 4; k++)
            chk($sformatf("u%0d_read_data", k), o_rd[k], rs_c[k] ? m_trig(k) : value);
    endtask

    task automatic compare_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("u%0d_trigger", k), o_trg[k], m_trig(k));
            chk($sformatf("u%0d_busy", k),    o_bsy[k], m_trig(k));
            chk($sformatf("u%0d_sw_value", k), o_val[k], m_trig(k));
            chk($sformatf("u%0d_overrun", k), o_ovr[k], m_ovr(k));
        end
        check_rd();
    endtask

    task automatic idle_inputs();
        rv = 1'b0; wv = 1'b0; we = 1'b0; mask = '0; wd = '0; ack = '0;
    endtask

    task automatic write(input logic [7:0] d, input logic [7:0] m);
        idle_inputs();
        wv = 1'b1; we = 1'b1; wd = d; mask = m;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step();
        #1 check_rd();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst = 1'b1;
        model_clear();
        #1 compare_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 compare_all();
    endtask

    int h;

    initial begin
        rst = 1'b1;
        value = 8'h00;
        idle_inputs();
        model_clear();
        @(negedge clk);
        do_reset();
        chk("reset_u0_trigger", o_trg[0], 8'h00);
        chk("reset_u3_overrun", o_ovr[3], 8'h00);

        // Write-1 pattern, 1-cycle pulse on u0; write-0 trigger on u3 fires the complement.
        write(8'hA5, 8'hFF); step();
        chk("t1_u0_pulse", o_trg[0], 8'hA5);
        chk("t1_u3_pulse", o_trg[3], 8'h5A);
        idle_inputs(); step();
        chk("t1_u0_after", o_trg[0], 8'h00);
        do_reset();

        // 4-cycle pulse, refire during pulse: no extension, overrun set.
        h = 0;
        write(8'h01, 8'h01); step(); h += int'(o_trg[1][0]);
        idle_inputs();       step(); h += int'(o_trg[1][0]);
        write(8'h01, 8'h01); step(); h += int'(o_trg[1][0]);
        chk("t2_overrun_set", o_ovr[1], 8'h01);
        idle_inputs();       step(); h += int'(o_trg[1][0]);
        idle_inputs();       step(); h += int'(o_trg[1][0]);
        idle_inputs();       step(); h += int'(o_trg[1][0]);
        chk("t2_pulse_len", h, 4);
        chk("t2_pulse_end", o_trg[1], 8'h00);
        idle_inputs(); rv = 1'b1; mask = 8'h01; step();
        chk("t2_overrun_clr", o_ovr[1], 8'h00);
        write(8'h01, 8'h01); step();
        write(8'h01, 8'h01); rv = 1'b1; step();
        chk("t2_set_and_clr", o_ovr[1], 8'h01);
        do_reset();

        // Fire on the edge a 1-cycle pulse ends: treated as busy.
        write(8'h01, 8'h01); step();
        write(8'h01, 8'h01); step();
        chk("t2b_no_refire", o_trg[0], 8'h00);
        chk("t2b_overrun", o_ovr[0], 8'h01);
        do_reset();

        // Ack mode: held until ack, ack while idle or on the entry edge ignored.
        h = 0;
        write(8'h08, 8'h08); step(); h += int'(o_trg[2][3]);
        chk("t3_rise", o_trg[2], 8'h08);
        for (int i = 0; i < 10; i++) begin
            idle_inputs(); step(); h += int'(o_trg[2][3]);
        end
        chk("t3_busy_read", o_rd[2], 8'h08);
        idle_inputs(); ack = 8'h08; step();
        chk("t3_high_cycles", h, 11);
        chk("t3_fall", o_trg[2], 8'h00);
        idle_inputs(); ack = 8'h08; step();
        chk("t3_idle_ack", o_trg[2], 8'h00);
        write(8'h08, 8'h08); ack = 8'h08; step();
        chk("t3_entry_ack", o_trg[2], 8'h08);
        idle_inputs(); step();
        chk("t3_still_high", o_trg[2], 8'h08);
        idle_inputs(); ack = 8'h08; step();
        chk("t3_acked", o_trg[2], 8'h00);

        // Masking, write-0 trigger and write enable.
        do_reset();
        write(8'h0F, 8'h3C); step();
        chk("t4_u3_masked", o_trg[3], 8'h30);
        chk("t4_u0_masked", o_trg[0], 8'h0C);
        do_reset();
        write(8'h0F, 8'h3C); we = 1'b0; step();
        chk("t4_u3_disabled", o_trg[3], 8'h00);
        chk("t4_u0_disabled", o_trg[0], 8'h00);

        // Read-back selection.
        do_reset();
        write(8'h42, 8'h42); step();
        chk("t5_status_both", o_rd[2], 8'h42);
        idle_inputs(); ack = 8'h02; step();
        chk("t5_status_one", o_rd[2], 8'h40);
        idle_inputs(); ack = 8'h40; step();
        chk("t5_status_none", o_rd[2], 8'h00);
        idle_inputs();
        value = 8'h3C; #1 chk("t5_value_a", o_rd[0], 8'h3C);
        value = 8'hC3; #1 chk("t5_value_b", o_rd[1], 8'hC3);

        // Asynchronous reset mid-pulse and mid ack-wait.
        do_reset();
        write(8'h00, 8'h01); step();
        write(8'h02, 8'h02); step();
        idle_inputs(); step();
        chk("t6_u3_midpulse", o_trg[3], 8'h01);
        chk("t6_u2_waiting", o_trg[2], 8'h02);
        #2 rst = 1'b1;
        model_clear();
        #1;
        chk("t6_u3_async_clr", o_trg[3], 8'h00);
        chk("t6_u2_async_clr", o_trg[2], 8'h00);
        chk("t6_u2_read_clr", o_rd[2], 8'h00);
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle_inputs(); step();
        end
        chk("t6_no_residual", o_trg[3], 8'h00);
        write(8'h00, 8'h01); step();
        chk("t6_refire", o_trg[3], 8'h01);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rv    = ($urandom % 5) == 0;
            wv    = ($urandom % 3) == 0;
            we    = ($urandom % 5) != 0;
            mask  = 8'($urandom);
            wd    = 8'($urandom);
            value = 8'($urandom);
            ack   = 8'($urandom) & 8'($urandom);
            step();
            if (($urandom % 250) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
